// File: rtl/popcount20_vecgen_if.sv
// Request/result handshake bundle for popcount20_vecgen.
// slave = generator side, master = requester/consumer side.
interface popcount20_vecgen_if #(
  parameter int N = 20
);
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_count;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_vec;
  logic [4:0]   out_count;

  modport master (
    output in_valid,
    output in_count,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_vec,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_count,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_vec,
    output out_count
  );
endinterface

// File: rtl/popcount20_vecgen.sv
// Hamming-weight-controlled 20-bit vector generator.
// Sets (or clears) one LFSR-chosen free bit per cycle until weight k is reached.
module popcount20_vecgen #(
  parameter int          N    = 20,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  popcount20_vecgen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
  } state_t;

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t       r_state;
  logic [15:0]  r_lfsr;
  logic [N-1:0] r_vec;
  logic [3:0]   r_rem;
  logic         r_cmp;
  logic [4:0]   r_kreg;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [N-1:0] r_out_vec;
  logic [4:0]   r_out_count;

  logic         w_fb;
  logic [4:0]   w_sat;
  logic         w_big;
  logic [3:0]   w_rem0;
  logic [N-1:0] w_vec0;
  logic [4:0]   w_s5;
  logic [4:0]   w_start;
  logic [N-1:0] w_hit;
  logic [5:0]   w_idx;
  logic         w_found;
  logic [4:0]   w_j;
  logic [N-1:0] w_flip;
  logic [N-1:0] w_vec_nx;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13]
              ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_sat  = (bus.in_count > 5'd20) ?
                  5'd20 : bus.in_count;
  // Above half weight, start full and clear bits instead.
  assign w_big  = (w_sat > 5'd10);
  assign w_rem0 = w_big ? 4'(5'd20 - w_sat)
                        : w_sat[3:0];
  assign w_vec0 = w_big ? '1 : '0;

  assign w_s5    = r_lfsr[4:0];
  assign w_start = (w_s5 >= 5'd20) ?
                   (w_s5 - 5'd20) : w_s5;
  assign w_hit   = r_cmp ? r_vec : ~r_vec;

  always_comb begin
    w_found = 1'b0;
    w_j     = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, w_start} + 6'(i);
      if (w_idx >= 6'd20)
        w_idx = w_idx - 6'd20;
      if (!w_found && w_hit[w_idx[4:0]]) begin
        w_found = 1'b1;
        w_j     = w_idx[4:0];
      end
    end
  end

  assign w_flip   = w_found ?
                    (N'(1) << w_j) : '0;
  assign w_vec_nx = r_vec ^ w_flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED_EFF;
      r_vec       <= '0;
      r_rem       <= '0;
      r_cmp       <= 1'b0;
      r_kreg      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      r_out_count <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_kreg     <= w_sat;
            r_cmp      <= w_big;
            r_vec      <= w_vec0;
            r_rem      <= w_rem0;
            r_in_ready <= 1'b0;
            if (w_rem0 != 4'd0) begin
              r_state <= S_FILL;
            end else begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_out_vec   <= w_vec0;
              r_out_count <= w_sat;
            end
          end
        end
        S_FILL: begin
          r_vec <= w_vec_nx;
          r_rem <= r_rem - 4'd1;
          if (r_rem == 4'd1) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_out_vec   <= w_vec_nx;
            r_out_count <= r_kreg;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_vec   = r_out_vec;
  assign bus.out_count = r_out_count;

endmodule

// File: tb/tb_popcount20_vecgen.sv
// Bench for popcount20_vecgen: vector table, sweep,
// backpressure, mid-FILL reset, random run and replay.
module tb_popcount20_vecgen;

  logic clk;
  logic rst_n;

  popcount20_vecgen_if #(.N(20)) bif ();

  popcount20_vecgen #(
    .N(20),
    .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  k;
    logic [4:0]  cnt;
    int          lat;
    bit          cv;
    logic [19:0] ev;
  } vec_t;

  typedef struct {
    logic [4:0]  cnt;
    int          lat;
    bit          cv;
    logic [19:0] ev;
  } exp_t;

  exp_t sb[$];
  int n_err;
  int n_checks;

  function automatic int pc(logic [19:0] v);
    int c = 0;
    for (int i = 0; i < 20; i++)
      c += int'(v[i]);
    return c;
  endfunction

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [4:0] k);
    exp_t e;
    int s;
    int m;
    s = (k > 5'd20) ? 20 : int'(k);
    m = (s < 20 - s) ? s : 20 - s;
    e.cnt = 5'(s);
    e.lat = m + 1;
    e.cv  = 1'b0;
    e.ev  = '0;
    return e;
  endfunction

  // Sampling point: #1 after posedge.
  task automatic run_req(input logic [4:0] k,
                         input exp_t e,
                         input int stall,
                         output logic [19:0] got);
    exp_t x;
    int n;
    int lat;
    logic [19:0] hv;
    logic [4:0] hc;
    got = '0;
    bif.in_count  = k;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b0;
    n = 0;
    while (!bif.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bif.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      bif.in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    chk("in_ready_low_c1",
        32'(bif.in_ready), 0);
    lat = 1;
    while (!bif.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    if (!bif.out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("latency", lat, x.lat);
    chk("out_count", 32'(bif.out_count),
        32'(x.cnt));
    chk("weight", pc(bif.out_vec),
        int'(x.cnt));
    if (x.cv)
      chk("out_vec", 32'(bif.out_vec),
          32'(x.ev));
    hv  = bif.out_vec;
    hc  = bif.out_count;
    got = hv;
    for (int i = 0; i < stall; i++) begin
      bif.in_count = 5'd3;
      bif.in_valid = ~bif.in_valid;
      @(posedge clk); #1;
      chk("stall_valid",
          32'(bif.out_valid), 1);
      chk("stall_in_ready",
          32'(bif.in_ready), 0);
      chk("stall_vec", 32'(bif.out_vec),
          32'(hv));
      chk("stall_cnt", 32'(bif.out_count),
          32'(hc));
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    chk("post_hs_valid",
        32'(bif.out_valid), 0);
    chk("post_hs_ready",
        32'(bif.in_ready), 1);
  endtask

  task automatic apply_reset();
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.in_count  = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  logic [4:0]  rk[150];
  int          rs[150];
  logic [19:0] rv[150];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] got;
    exp_t e;
    int seen;
    n_err = 0;
    n_checks = 0;

    tbl[0] = '{5'd0,  5'd0,  1,  1'b1, 20'h00000};
    tbl[1] = '{5'd20, 5'd20, 1,  1'b1, 20'hFFFFF};
    tbl[2] = '{5'd31, 5'd20, 1,  1'b1, 20'hFFFFF};
    tbl[3] = '{5'd21, 5'd20, 1,  1'b1, 20'hFFFFF};
    tbl[4] = '{5'd7,  5'd7,  8,  1'b0, 20'h0};
    tbl[5] = '{5'd13, 5'd13, 8,  1'b0, 20'h0};
    tbl[6] = '{5'd10, 5'd10, 11, 1'b0, 20'h0};
    tbl[7] = '{5'd1,  5'd1,  2,  1'b0, 20'h0};
    tbl[8] = '{5'd19, 5'd19, 2,  1'b0, 20'h0};
    tbl[9] = '{5'd11, 5'd11, 10, 1'b0, 20'h0};

    rst_n = 1'b1;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.in_count  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bif.out_valid), 0);
    chk("rst_out_vec", 32'(bif.out_vec), 0);
    chk("rst_out_count", 32'(bif.out_count), 0);
    chk("rst_in_ready", 32'(bif.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("lfsr_seed", 32'(dut.r_lfsr), 32'hACE1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      e.cnt = tbl[i].cnt;
      e.lat = tbl[i].lat;
      e.cv  = tbl[i].cv;
      e.ev  = tbl[i].ev;
      run_req(tbl[i].k, e, 0, got);
    end

    for (int k = 0; k <= 20; k++)
      run_req(5'(k), mk(5'(k)), 0, got);

    run_req(5'd5, mk(5'd5), 6, got);

    bif.in_count = 5'd9;
    bif.in_valid = 1'b1;
    seen = 0;
    while (!bif.in_ready && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bif.out_valid), 0);
    chk("mid_rst_vec", 32'(bif.out_vec), 0);
    chk("mid_rst_count", 32'(bif.out_count), 0);
    chk("mid_rst_ready", 32'(bif.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bif.out_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    run_req(5'd9, mk(5'd9), 0, got);

    for (int i = 0; i < 1500; i++) begin
      logic [4:0] k;
      k = 5'($urandom_range(0, 31));
      run_req(k, mk(k), $urandom_range(0, 3), got);
    end

    for (int i = 0; i < 150; i++) begin
      rk[i] = 5'($urandom_range(0, 31));
      rs[i] = $urandom_range(0, 4);
    end
    apply_reset();
    for (int i = 0; i < 150; i++)
      run_req(rk[i], mk(rk[i]), rs[i], rv[i]);
    apply_reset();
    for (int i = 0; i < 150; i++) begin
      run_req(rk[i], mk(rk[i]), rs[i], got);
      chk("replay_vec", 32'(got), 32'(rv[i]));
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_checks);
    $finish;
  end

endmodule
